cb_module: RTL and testbench

- Serially programmed FPGA connection box with a small embedded logic function, one per routing tile.
- Four 4-bit input tracks are routed bit-wise onto four 4-bit output pins by a 69-bit configuration shift register.
- Each output pin can optionally take a shared 4-input LUT result, be inverted, be registered, or be disabled.
- Configuration is loaded serially through `prog_in`. `prog_out` chains tiles together.

---
 rtl/cb_module.sv | 94 +++++++++
 tb/tb_cb_module.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_module.sv
// Serially programmed connection box: four 4-bit tracks routed per bit onto four 4-bit pins,
// with a shared 4-input LUT, per-pin invert/register/disable. Optional macro: CB_PROG_GATE_EN.
module cb_module #(
    parameter int CFG_W = 69,
    parameter int TRK_W = 4
) (
    input  logic             clb_clk,
    input  logic             rst_n,
    input  logic             prog_in,
    input  logic             prog_en,
    output logic             prog_out,
    input  logic [TRK_W-1:0] in1,
    input  logic [TRK_W-1:0] in2,
    input  logic [TRK_W-1:0] in3,
    input  logic [TRK_W-1:0] in4,
    output logic [TRK_W-1:0] out1,
    output logic [TRK_W-1:0] out2,
    output logic [TRK_W-1:0] out3,
    output logic [TRK_W-1:0] out4
);

    localparam int N_OUT     = 4;
    localparam int MODE_W    = 5;
    localparam int ROUTE_LSB = 20;
    localparam int LUT_LSB   = 52;
    localparam int OE_BIT    = 68;

    logic [CFG_W-1:0]              cfg;
    logic [N_OUT-1:0][TRK_W-1:0]   trk;
    logic [N_OUT-1:0][TRK_W-1:0]   v;
    logic [N_OUT-1:0][TRK_W-1:0]   q;
    logic [N_OUT-1:0][TRK_W-1:0]   o;
    logic [3:0]                    mode;   // reserved mode bit 4 is never decoded
    logic [1:0]                    sel;
    logic [3:0]                    lut_addr;
    logic                          r_bit;
    logic                          lut_bit;
    logic                          pin_en;

    assign trk      = {in4, in3, in2, in1};
    assign prog_out = cfg[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= '0;
        end else if (prog_en) begin
            cfg <= {prog_in, cfg[CFG_W-1:1]};
        end
    end

    // Output flops capture continuously, even while the chain is shifting.
    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= v;
        end
    end

`ifdef CB_PROG_GATE_EN
    assign pin_en = cfg[OE_BIT] & ~prog_en;
`else
    assign pin_en = cfg[OE_BIT];
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        v        = '0;
        o        = '0;
        mode     = '0;
        sel      = '0;
        lut_addr = '0;
        r_bit    = 1'b0;
        lut_bit  = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            mode = cfg[MODE_W*k +: 4];
            for (int j = 0; j < TRK_W; j++) begin
                sel      = cfg[ROUTE_LSB + 2*TRK_W*k + 2*j +: 2];
                r_bit    = trk[sel][j];
                lut_addr = {trk[3][j], trk[2][j], trk[1][j], trk[0][j]};
                lut_bit  = cfg[LUT_LSB + int'(lut_addr)];
                v[k][j]  = (mode[2] ? lut_bit : r_bit) ^ mode[0];
                o[k][j]  = pin_en & ~mode[3] & (mode[1] ? q[k][j] : v[k][j]);
            end
        end
    end

    assign out1 = o[0];
    assign out2 = o[1];
    assign out3 = o[2];
    assign out4 = o[3];

endmodule

// File: tb/tb_cb_module.sv
// Self-checking bench for cb_module: directed scenarios plus randomized configs/inputs
// compared against a spec-level reference model of the config word and output flops.
module tb_cb_module;

    logic       clb_clk;
    logic       rst_n;
    logic       prog_in;
    logic       prog_en;
    logic       prog_out;
    logic [3:0] in1, in2, in3, in4;
    logic [3:0] out1, out2, out3, out4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [68:0] mcfg;   // model configuration word
    logic [15:0] mq;     // model output flops, {q4,q3,q2,q1}

    cb_module dut (
        .clb_clk (clb_clk),
        .rst_n   (rst_n),
        .prog_in (prog_in),
        .prog_en (prog_en),
        .prog_out(prog_out),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in4     (in4),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4)
    );

    initial begin
        clb_clk = 1'b0;
        forever #5 clb_clk = ~clb_clk;
    end

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cur_ins();
        return {in4, in3, in2, in1};
    endfunction

    function automatic logic [15:0] cur_outs();
        return {out4, out3, out2, out1};
    endfunction

    // Value each pin bit would present before the register/gating stage.
    function automatic logic [15:0] model_v(input logic [68:0] c, input logic [15:0] ins);
        logic [3:0] track [4];
        logic [15:0] res;
        for (int t = 0; t < 4; t++) track[t] = ins[4*t +: 4];
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                int s, a;
                logic b;
                s = int'(c[20 + 8*k + 2*j +: 2]);
                a = 8*int'(track[3][j]) + 4*int'(track[2][j]) + 2*int'(track[1][j]) + int'(track[0][j]);
                b = c[5*k + 2] ? c[52 + a] : track[s][j];
                res[4*k + j] = b ^ c[5*k];
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] model_out(input logic [68:0] c, input logic [15:0] ins,
                                              input logic [15:0] q, input logic pen);
        logic [15:0] v, res;
        v = model_v(c, ins);
        for (int k = 0; k < 4; k++) begin
            logic en;
            en = c[68] && !c[5*k + 3];
`ifdef CB_PROG_GATE_EN
            en = en && !pen;
`endif
            res[4*k +: 4] = en ? (c[5*k + 1] ? q[4*k +: 4] : v[4*k +: 4]) : 4'b0000;
        end
        return res;
    endfunction

    task automatic check_outs(input string tag);
        check(tag, 69'(cur_outs()), 69'(model_out(mcfg, cur_ins(), mq, prog_en)));
    endtask

    // One clock edge; the model advances using the values present just before it.
    task automatic step();
        logic [15:0] vn;
        vn = model_v(mcfg, cur_ins());
        @(posedge clb_clk);
        if (prog_en) mcfg = {prog_in, mcfg[68:1]};
        mq = vn;
        #1;
    endtask

    task automatic load_cfg(input logic [68:0] c);
        prog_en = 1'b1;
        for (int i = 0; i < 69; i++) begin
            prog_in = c[i];
            step();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    task automatic set_ins(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        in1 = a; in2 = b; in3 = c; in4 = d;
        #1;
    endtask

    function automatic logic [68:0] identity_cfg();
        logic [68:0] c;
        c = '0;
        c[68] = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                c[20 + 8*k + 2*j +: 2] = 2'(k);
        return c;
    endfunction

    initial begin
        logic [68:0] c, pat, got;
        logic early;
        logic [15:0] snap;

        rst_n = 1'b0; prog_in = 1'b0; prog_en = 1'b0;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        mcfg = '0; mq = '0;
        #12;
        check("reset_outs", 69'(cur_outs()), 69'd0);
        check("reset_prog_out", 69'(prog_out), 69'd0);
        @(negedge clb_clk);
        rst_n = 1'b1;

        // Scenario 1: load something live, then reset asynchronously mid-cycle.
        c = identity_cfg();
        c[0] = 1'b1;
        load_cfg(c);
        set_ins(4'b0100, 4'b0001, 4'b1001, 4'b0011);
        check("pre_reset_outs", 69'(cur_outs()), 69'(model_out(mcfg, cur_ins(), mq, prog_en)));
        #2;
        rst_n = 1'b0;
        mcfg = '0; mq = '0;
        #1;
        check("async_reset_outs", 69'(cur_outs()), 69'd0);
        check("async_reset_prog_out", 69'(prog_out), 69'd0);
        @(negedge clb_clk);
        rst_n = 1'b1;
        got = '0;
        prog_en = 1'b1; prog_in = 1'b0;
        for (int i = 0; i < 69; i++) begin
            got[i] = prog_out;
            step();
        end
        prog_en = 1'b0;
        check("reset_cfg_readback", got, 69'd0);

        // Scenario 2: chain delay of exactly 69 cycles, then hold with prog_en low.
        pat = {$urandom, $urandom, $urandom};
        pat[0] = 1'b1;
        got = '0; early = 1'b0;
        prog_en = 1'b1;
        for (int n = 1; n <= 138; n++) begin
            prog_in = (n <= 69) ? pat[n-1] : 1'b0;
            step();
            if (n < 69) early = early | prog_out;
            else if (n <= 137) got[n-69] = prog_out;
        end
        check("chain_early", 69'(early), 69'd0);
        check("chain_pattern", got, pat);
        load_cfg(pat);
        for (int i = 0; i < 10; i++) begin
            prog_in = 1'($urandom);
            step();
        end
        got = '0;
        prog_en = 1'b1; prog_in = 1'b0;
        for (int i = 0; i < 69; i++) begin
            got[i] = prog_out;
            step();
        end
        prog_en = 1'b0;
        check("chain_hold", got, pat);

        // Scenario 3: identity routing.
        load_cfg(identity_cfg());
        set_ins(4'b0100, 4'b0001, 4'b1001, 4'b0011);
        check("identity", 69'(cur_outs()), 69'({4'b0011, 4'b1001, 4'b0001, 4'b0100}));

        // Scenario 4: cross-route, invert, disable, global enable off.
        c = identity_cfg();
        for (int j = 0; j < 4; j++) c[20 + 2*j +: 2] = 2'd3;
        c[5] = 1'b1;
        c[13] = 1'b1;
        load_cfg(c);
        check("route_inv_dis", 69'(cur_outs()), 69'({4'b0011, 4'b0000, 4'b1110, 4'b0011}));
        c[68] = 1'b0;
        load_cfg(c);
        check("global_disable", 69'(cur_outs()), 69'd0);

        // Scenario 5: LUT select, then registered path latency.
        c = identity_cfg();
        c[52 +: 16] = 16'hEEEE;
        c[2] = 1'b1;
        load_cfg(c);
        check("lut_comb", 69'(out1), 69'(4'b0101));
        c[1] = 1'b1;
        load_cfg(c);
        step();
        check("lut_reg_settled", 69'(out1), 69'(4'b0101));
        set_ins(4'b0100, 4'b1111, 4'b1001, 4'b0011);
        check("lut_reg_before_edge", 69'(out1), 69'(4'b0101));
        step();
        check("lut_reg_after_edge", 69'(out1), 69'(4'b1111));

        // Scenario 6: raising prog_en over a valid configuration.
        load_cfg(identity_cfg());
        set_ins(4'b0100, 4'b0001, 4'b1001, 4'b0011);
        prog_en = 1'b1; prog_in = 1'b0;
        #1;
`ifdef CB_PROG_GATE_EN
        check("prog_gate_outs", 69'(cur_outs()), 69'd0);
`else
        check("prog_live_outs", 69'(cur_outs()), 69'({4'b0011, 4'b1001, 4'b0001, 4'b0100}));
`endif
        for (int i = 0; i < 6; i++) begin
            prog_in = 1'($urandom);
            step();
            check_outs("prog_shift_outs");
        end
        prog_en = 1'b0;
        #1;
        check_outs("prog_drop_outs");

        // Randomized configurations, inputs and occasional shifting.
        for (int t = 0; t < 15; t++) begin
            c = {$urandom, $urandom, $urandom};
            c[68] = ($urandom_range(0, 3) != 0);
            load_cfg(c);
            for (int i = 0; i < 12; i++) begin
                set_ins(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
                prog_en = ($urandom_range(0, 5) == 0);
                prog_in = 1'($urandom);
                #1;
                check_outs("rand_comb");
                snap = mq;
                step();
                check_outs("rand_edge");
            end
            prog_en = 1'b0;
            if (snap == 16'hxxxx) check("rand_snap", 69'(snap), 69'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
